// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO for producer/consumer paths that share one clock.
//   Provides programmable almost-full / almost-empty flags, a fill-level
//   output, sticky overflow / underflow error flags and an optional
//   first-word-fall-through (FWFT) read mode.
//
// Parameters
//   WIDTH     data word width
//   POINTER   address width, DEPTH = 2**POINTER
//   AF_THRESH wr_almost_full when level >= AF_THRESH
//   AE_THRESH rd_almost_empty when level <= AE_THRESH
//   FWFT      0 = registered read (1-cycle latency), 1 = fall-through
//
// Ports
//   aclk            in   clock, rising edge
//   srst            in   synchronous reset, active high
//   wren            in   write request
//   data_in         in   write data
//   wr_full         out  level == DEPTH
//   wr_almost_full  out  level >= AF_THRESH
//   rden            in   read request (pop)
//   data_out        out  read data
//   rd_valid        out  data_out carries a popped word
//   rd_empty        out  level == 0
//   rd_almost_empty out  level <= AE_THRESH
//   level           out  occupancy 0..DEPTH
//   overflow        out  sticky: write attempted while full
//   underflow       out  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int POINTER   = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic               aclk,
    input  logic               srst,
    input  logic               wren,
    input  logic [WIDTH-1:0]   data_in,
    output logic               wr_full,
    output logic               wr_almost_full,
    input  logic               rden,
    output logic [WIDTH-1:0]   data_out,
    output logic               rd_valid,
    output logic               rd_empty,
    output logic               rd_almost_empty,
    output logic [POINTER:0]   level,
    output logic               overflow,
    output logic               underflow
);

    localparam int               DEPTH   = 2 ** POINTER;
    localparam logic [POINTER:0] DEPTH_L = (POINTER+1)'(DEPTH);
    localparam logic [POINTER:0] AF_L    = (POINTER+1)'(AF_THRESH);
    localparam logic [POINTER:0] AE_L    = (POINTER+1)'(AE_THRESH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [POINTER-1:0] wr_ptr;
    logic [POINTER-1:0] rd_ptr;
    logic [POINTER:0]   level_nxt;
    logic               wr_accept;
    logic               rd_accept;

    // Acceptance uses the flags registered at the start of the cycle, so a
    // same-cycle read cannot make room for a write when full (and vice versa).
    assign wr_accept = wren & ~wr_full;
    assign rd_accept = rden & ~rd_empty;

    always_comb begin
        level_nxt = level;
        case ({wr_accept, rd_accept})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge aclk) begin
        if (!srst && wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Flags are derived from level_nxt so they line up with the new level.
    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            wr_full         <= 1'b0;
            wr_almost_full  <= 1'b0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level           <= level_nxt;
            wr_full         <= (level_nxt == DEPTH_L);
            wr_almost_full  <= (level_nxt >= AF_L);
            rd_empty        <= (level_nxt == '0);
            rd_almost_empty <= (level_nxt <= AE_L);
            if (wren && wr_full) begin
                overflow <= 1'b1;
            end
            if (rden && rd_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] dout_q;
            logic             valid_q;

            always_ff @(posedge aclk) begin
                if (srst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else if (rd_accept) begin
                    dout_q  <= mem[rd_ptr];
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end

            assign data_out = dout_q;
            assign rd_valid = valid_q;
        end else begin : g_fwft_read
            // Head of queue is always presented; contents are meaningless
            // while rd_empty is high.
            assign data_out = mem[rd_ptr];
            assign rd_valid = ~rd_empty;
        end
    endgenerate

endmodule
